branch_pc_sequencer: RTL and testbench
======================================

Name: branch_pc_sequencer

Overview:
- Multi-cycle next-PC controller for the MIPS core. Owns the PC register and sequences conditional branches through a fixed evaluate step, which gives the ALU one cycle to produce Zero.
- Redirects the PC and flushes the fetch stage when a branch is taken or a jump is decoded.
- Keeps saturating branch and taken-branch counters for performance debug.
- Sits between the control unit/ALU and instruction memory; re-implements the team's 3-bit branch-type condition decode internally.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 16, width of the branch and taken-branch counters

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous reset, active-low
stall_in  input  1  global stall; freezes all state and counters
instr_valid  input  1  decoded instruction present this cycle
Branch_type  input  3  000 none, 001 beq, 010 bne, 011 bltz, 100 blez, 101 bgtz, 110/111 none
Jump  input  1  unconditional jump (j/jal)
Imm_ext  input  32  sign-extended branch immediate, in words
Jump_target  input  26  jump target field
Zero  input  1  ALU zero flag, valid in EVAL
Rs_data  input  32  rs operand, valid in EVAL
PC  output  32  current program counter
branch_stall  output  1  high while in EVAL; upstream holds instruction
flush  output  1  high for exactly the REDIRECT cycle
Branch_taken  output  1  one-cycle pulse on the edge leaving EVAL taken
branch_cnt  output  CNT_W  conditional branches resolved
taken_cnt  output  CNT_W  conditional branches taken

Behaviour:
- Reset (rst_n=0 at a clock edge), from any state including mid-EVAL:
  - PC=RESET_PC, state=FETCH, both counters=0.
  - Branch_taken=0. branch_stall=0 and flush=0, since both are Moore outputs and state is FETCH.
- Captured registers: pc4_q = PC+4, imm_q, type_q.
- stall_in=1: nothing updates (PC, state, captured registers, counters); Branch_taken=0. stall_in has priority over every rule below except reset.
- FETCH, instr_valid=0: PC holds.
- FETCH, instr_valid=1, Jump=1 (Jump wins over any Branch_type):
  - PC <= {PC_plus4[31:28], Jump_target, 2'b00}.
  - state <= REDIRECT.
  - Counters unchanged.
- FETCH, instr_valid=1, Branch_type in 001..101:
  - Capture pc4_q, imm_q, type_q.
  - state <= EVAL. PC holds.
- FETCH, instr_valid=1, otherwise (including Branch_type 110/111): PC <= PC+4, mod 2^32.
- EVAL (one cycle unless stalled):
  - Flags derived from Rs_data: ltz=Rs[31]; lez=Rs[31]|(Rs==0); gtz=~Rs[31]&(Rs!=0).
  - taken per type_q: beq=Zero, bne=~Zero, bltz=ltz, blez=lez, bgtz=gtz.
  - Taken: PC <= pc4_q + (imm_q<<2), mod 2^32; state <= REDIRECT; Branch_taken pulses.
  - Not taken: PC <= pc4_q; state <= FETCH.
  - branch_cnt increments in both cases; taken_cnt increments if taken. Both saturate at all-ones.
- REDIRECT: flush=1; PC holds; state <= FETCH next edge; instr_valid is ignored this cycle.
- Latency:
  - Not-taken branch: 2 cycles FETCH to FETCH.
  - Taken branch: 3 cycles (FETCH, EVAL, REDIRECT).
  - Jump: 2 cycles (FETCH, REDIRECT).

Test Plan:
- Reset, then 4 cycles of instr_valid=1 with Branch_type=000 -> PC=0,4,8,C,10. branch_stall=0, flush=0 throughout.
- PC=0x40, beq with Imm_ext=3, Zero=1 in EVAL -> branch_stall=1 for 1 cycle; then PC=0x50, flush=1 for 1 cycle, Branch_taken pulse; branch_cnt=1, taken_cnt=1.
- PC=0x40, bgtz with Rs_data=0 -> not taken, PC=0x44, no flush; branch_cnt=1, taken_cnt=0. Repeat with Rs=0xFFFFFFFF for blez -> taken.
- PC=0x3000_0010, Jump=1, Branch_type=001, Jump_target=0x100 -> PC=0x3000_0400, flush=1, counters unchanged.
- stall_in=1 held 3 cycles during EVAL -> state, PC and counters frozen; resolves correctly the cycle after stall_in falls. Separately, rst_n=0 during EVAL -> PC=RESET_PC, FETCH, counters 0.
- CNT_W=2, 5 taken branches -> branch_cnt=taken_cnt=3 (saturated). Also bne with Imm_ext=0xFFFFFFFF at PC=0 -> PC=0x0000_0000 (4 - 4); Imm_ext=-2 -> PC=0xFFFF_FFFC (wrap).

Source files
------------

// File: rtl/branch_pc_sequencer_if.sv
// Decode/ALU-side bundle for branch_pc_sequencer: instruction and operand inputs,
// program counter and pipeline-control outputs.
interface branch_pc_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    logic             stall_in;
    logic             instr_valid;
    logic [2:0]       Branch_type;
    logic             Jump;
    logic [31:0]      Imm_ext;
    logic [25:0]      Jump_target;
    logic             Zero;
    logic [31:0]      Rs_data;

    logic [31:0]      PC;
    logic             branch_stall;
    logic             flush;
    logic             Branch_taken;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] taken_cnt;

    // Control unit / ALU side
    modport master (
        output stall_in, instr_valid, Branch_type, Jump, Imm_ext, Jump_target, Zero, Rs_data,
        input  PC, branch_stall, flush, Branch_taken, branch_cnt, taken_cnt
    );

    // Sequencer side
    modport slave (
        input  stall_in, instr_valid, Branch_type, Jump, Imm_ext, Jump_target, Zero, Rs_data,
        output PC, branch_stall, flush, Branch_taken, branch_cnt, taken_cnt
    );
endinterface

// File: rtl/branch_pc_sequencer.sv
// Multi-cycle next-PC controller: owns the PC, resolves conditional branches in a
// dedicated EVAL cycle, redirects/flushes fetch on taken branches and jumps.
module branch_pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    branch_pc_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        EVAL     = 2'd1,
        REDIRECT = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_BEQ  = 3'b001,
        BR_BNE  = 3'b010,
        BR_BLTZ = 3'b011,
        BR_BLEZ = 3'b100,
        BR_BGTZ = 3'b101
    } br_type_e;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic             taken_q, taken_d;

    logic [31:0]      pc4_q, pc4_d;
    logic [31:0]      imm_q, imm_d;
    br_type_e         type_q, type_d;

    logic [31:0]      pc_plus4;
    logic             is_branch;
    logic             rs_zero, ltz, lez, gtz;
    logic             cond;

    assign pc_plus4  = pc_q + 32'd4;
    assign is_branch = (bus.Branch_type >= 3'b001) && (bus.Branch_type <= 3'b101);

    // Sign/zero flags of rs, consumed only while resolving in EVAL
    assign rs_zero = (bus.Rs_data == 32'd0);
    assign ltz     = bus.Rs_data[31];
    assign lez     = ltz | rs_zero;
    assign gtz     = ~ltz & ~rs_zero;

    always_comb begin
        cond = 1'b0;
        case (type_q)
            BR_BEQ:  cond = bus.Zero;
            BR_BNE:  cond = ~bus.Zero;
            BR_BLTZ: cond = ltz;
            BR_BLEZ: cond = lez;
            BR_BGTZ: cond = gtz;
            default: cond = 1'b0;
        endcase
    end

    // Next-state and datapath update; stall_in freezes everything.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d = state_q;
        pc_d    = pc_q;
        bcnt_d  = bcnt_q;
        tcnt_d  = tcnt_q;
        taken_d = 1'b0;
        pc4_d   = pc4_q;
        imm_d   = imm_q;
        type_d  = type_q;

        if (!bus.stall_in) begin
            case (state_q)
                FETCH: begin
                    if (bus.instr_valid) begin
                        if (bus.Jump) begin
                            pc_d    = {pc_plus4[31:28], bus.Jump_target, 2'b00};
                            state_d = REDIRECT;
                        end else if (is_branch) begin
                            pc4_d   = pc_plus4;
                            imm_d   = bus.Imm_ext;
                            type_d  = br_type_e'(bus.Branch_type);
                            state_d = EVAL;
                        end else begin
                            pc_d = pc_plus4;
                        end
                    end
                end
                EVAL: begin
                    bcnt_d = (bcnt_q == '1) ? bcnt_q : bcnt_q + CNT_W'(1);
                    if (cond) begin
                        pc_d    = pc4_q + (imm_q << 2);
                        tcnt_d  = (tcnt_q == '1) ? tcnt_q : tcnt_q + CNT_W'(1);
                        taken_d = 1'b1;
                        state_d = REDIRECT;
                    end else begin
                        pc_d    = pc4_q;
                        state_d = FETCH;
                    end
                end
                REDIRECT: state_d = FETCH;
                default:  state_d = FETCH;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            bcnt_q  <= '0;
            tcnt_q  <= '0;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            bcnt_q  <= bcnt_d;
            tcnt_q  <= tcnt_d;
            taken_q <= taken_d;
        end
    end

    // NOTE: captured branch operands carry no reset; they are always written in
    // FETCH before EVAL reads them.
    always_ff @(posedge clk) begin
        pc4_q  <= pc4_d;
        imm_q  <= imm_d;
        type_q <= type_d;
    end

    assign bus.PC           = pc_q;
    assign bus.branch_stall = (state_q == EVAL);
    assign bus.flush        = (state_q == REDIRECT);
    assign bus.Branch_taken = taken_q;
    assign bus.branch_cnt   = bcnt_q;
    assign bus.taken_cnt    = tcnt_q;

endmodule

// File: tb/tb_branch_pc_sequencer.sv
// Self-checking bench for branch_pc_sequencer: directed scenarios plus random
// instruction streams against a transaction-level PC/counter model.
module tb_branch_pc_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_in, instr_valid, Jump, Zero;
    logic [2:0]  Branch_type;
    logic [31:0] Imm_ext, Rs_data;
    logic [25:0] Jump_target;

    branch_pc_sequencer_if #(.CNT_W(16)) bus_a ();
    branch_pc_sequencer_if #(.CNT_W(2))  bus_b ();

    assign bus_a.stall_in    = stall_in;
    assign bus_a.instr_valid = instr_valid;
    assign bus_a.Branch_type = Branch_type;
    assign bus_a.Jump        = Jump;
    assign bus_a.Imm_ext     = Imm_ext;
    assign bus_a.Jump_target = Jump_target;
    assign bus_a.Zero        = Zero;
    assign bus_a.Rs_data     = Rs_data;
    assign bus_b.stall_in    = stall_in;
    assign bus_b.instr_valid = instr_valid;
    assign bus_b.Branch_type = Branch_type;
    assign bus_b.Jump        = Jump;
    assign bus_b.Imm_ext     = Imm_ext;
    assign bus_b.Jump_target = Jump_target;
    assign bus_b.Zero        = Zero;
    assign bus_b.Rs_data     = Rs_data;

    branch_pc_sequencer #(.RESET_PC(RESET_PC), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );
    branch_pc_sequencer #(.RESET_PC(RESET_PC), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    always #5 clk = ~clk;

    // Reference model: architectural PC plus unbounded resolved/taken counts
    logic [31:0] m_pc;
    int unsigned m_bcnt, m_tcnt;
    int n_checks = 0;
    int n_fail   = 0;

    typedef logic [105:0] snap_t;

    function automatic int unsigned sat(int unsigned v, int unsigned w);
        int unsigned mx = (32'd1 << w) - 32'd1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic ref_taken(logic [2:0] bt, logic z, logic [31:0] rs);
        case (bt)
            3'd1:    return z;
            3'd2:    return !z;
            3'd3:    return $signed(rs) < 0;
            3'd4:    return $signed(rs) <= 0;
            3'd5:    return $signed(rs) > 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] jump_dest(logic [31:0] pc, logic [25:0] tgt);
        return ((pc + 32'd4) & 32'hF000_0000) | ({6'd0, tgt} << 2);
    endfunction

    function automatic snap_t exp_snap(logic [31:0] pc, logic bs, logic fl, logic bt);
        logic [15:0] ba, ta;
        logic [1:0]  bb, tb2;
        ba  = 16'(sat(m_bcnt, 16));
        ta  = 16'(sat(m_tcnt, 16));
        bb  = 2'(sat(m_bcnt, 2));
        tb2 = 2'(sat(m_tcnt, 2));
        return {pc, bs, fl, bt, pc, bs, fl, bt, ba, ta, bb, tb2};
    endfunction

    function automatic snap_t obs_snap();
        return {bus_a.PC, bus_a.branch_stall, bus_a.flush, bus_a.Branch_taken,
                bus_b.PC, bus_b.branch_stall, bus_b.flush, bus_b.Branch_taken,
                bus_a.branch_cnt, bus_a.taken_cnt, bus_b.branch_cnt, bus_b.taken_cnt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        stall_in    = 1'b0;
        instr_valid = 1'b0;
        Jump        = 1'b0;
        Branch_type = 3'd0;
        Imm_ext     = $urandom();
        Jump_target = 26'($urandom());
        Zero        = 1'($urandom());
        Rs_data     = $urandom();
    endtask

    // One FETCH cycle of a non-branch slot (valid=0 holds, otherwise PC+4)
    task automatic do_seq(input logic [2:0] bt, input logic valid, input string name);
        snap_t e;
        drive_idle();
        instr_valid = valid;
        Branch_type = bt;
        tick();
        if (valid) m_pc = m_pc + 32'd4;
        e = exp_snap(m_pc, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs_snap() !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, obs_snap(), e);
        end
    endtask

    task automatic do_jump(input logic [25:0] tgt, input logic [2:0] bt, input string name);
        snap_t e;
        drive_idle();
        instr_valid = 1'b1;
        Jump        = 1'b1;
        Branch_type = bt;
        Jump_target = tgt;
        tick();
        m_pc = jump_dest(m_pc, tgt);
        e = exp_snap(m_pc, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (obs_snap() !== e) begin
            n_fail++;
            $display("FAIL %s redirect: got %h expected %h", name, obs_snap(), e);
        end
        // Junk instruction during REDIRECT must be ignored
        instr_valid = 1'b1;
        Jump        = 1'($urandom());
        Branch_type = 3'($urandom());
        Jump_target = 26'($urandom());
        tick();
        e = exp_snap(m_pc, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs_snap() !== e) begin
            n_fail++;
            $display("FAIL %s fetch: got %h expected %h", name, obs_snap(), e);
        end
    endtask

    task automatic do_branch(input logic [2:0] bt, input logic [31:0] imm, input logic z,
                             input logic [31:0] rs, input int nstall, input string name);
        snap_t e;
        logic  tk;
        drive_idle();
        instr_valid = 1'b1;
        Branch_type = bt;
        Imm_ext     = imm;
        tick();
        e = exp_snap(m_pc, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (obs_snap() !== e) begin
            n_fail++;
            $display("FAIL %s eval: got %h expected %h", name, obs_snap(), e);
        end
        for (int i = 0; i < nstall; i++) begin
            stall_in = 1'b1;
            Zero     = 1'($urandom());
            Rs_data  = $urandom();
            Imm_ext  = $urandom();
            tick();
            n_checks++;
            if (obs_snap() !== e) begin
                n_fail++;
                $display("FAIL %s stall%0d: got %h expected %h", name, i, obs_snap(), e);
            end
        end
        stall_in = 1'b0;
        Zero     = z;
        Rs_data  = rs;
        tick();
        tk = ref_taken(bt, z, rs);
        m_bcnt++;
        if (tk) begin
            m_tcnt++;
            m_pc = m_pc + 32'd4 + (imm << 2);
        end else begin
            m_pc = m_pc + 32'd4;
        end
        e = exp_snap(m_pc, 1'b0, tk, tk);
        n_checks++;
        if (obs_snap() !== e) begin
            n_fail++;
            $display("FAIL %s resolve: got %h expected %h", name, obs_snap(), e);
        end
        if (tk) begin
            instr_valid = 1'b1;
            Jump        = 1'($urandom());
            Branch_type = 3'($urandom());
            tick();
            e = exp_snap(m_pc, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (obs_snap() !== e) begin
                n_fail++;
                $display("FAIL %s after_redirect: got %h expected %h", name, obs_snap(), e);
            end
        end
    endtask

    task automatic test_reset();
        snap_t e;
        drive_idle();
        rst_n       = 1'b0;
        stall_in    = 1'b1;
        instr_valid = 1'b1;
        Jump        = 1'b1;
        tick();
        tick();
        m_pc = RESET_PC;
        m_bcnt = 0;
        m_tcnt = 0;
        e = exp_snap(m_pc, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs_snap() !== e) begin
            n_fail++;
            $display("FAIL reset: got %h expected %h", obs_snap(), e);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) do_seq(3'd0, 1'b1, "seq");
        do_seq(3'd0, 1'b0, "seq_idle");
        do_seq(3'd6, 1'b1, "seq_type6");
        do_seq(3'd7, 1'b1, "seq_type7");
    endtask

    task automatic test_beq_taken();
        do_jump(26'h10, 3'd0, "jump_to_40");
        do_branch(3'd1, 32'd3, 1'b1, $urandom(), 0, "beq_taken");
    endtask

    task automatic test_bgtz_blez();
        do_jump(26'h10, 3'd0, "jump_to_40b");
        do_branch(3'd5, 32'd7, $urandom(), 32'd0, 0, "bgtz_zero");
        do_branch(3'd4, 32'd5, $urandom(), 32'hFFFF_FFFF, 0, "blez_neg");
        do_branch(3'd3, 32'd2, $urandom(), 32'h8000_0000, 0, "bltz_min");
        do_branch(3'd2, 32'd2, 1'b1, $urandom(), 0, "bne_zero");
    endtask

    task automatic test_jump_priority();
        do_jump(26'h10, 3'd0, "jump_to_40c");
        do_branch(3'd1, 32'h0BFF_FFF2, 1'b1, 32'd0, 0, "beq_far");
        do_seq(3'd0, 1'b1, "seq_3000_0010");
        do_jump(26'h100, 3'd1, "jump_over_beq");
    endtask

    task automatic test_stall();
        snap_t e;
        drive_idle();
        instr_valid = 1'b1;
        Jump        = 1'b1;
        stall_in    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            e = exp_snap(m_pc, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (obs_snap() !== e) begin
                n_fail++;
                $display("FAIL fetch_stall%0d: got %h expected %h", i, obs_snap(), e);
            end
        end
        do_branch(3'd2, 32'd6, 1'b0, $urandom(), 3, "bne_stalled");
        do_branch(3'd5, 32'd6, $urandom(), 32'd9, 2, "bgtz_stalled");
    endtask

    task automatic test_reset_in_eval();
        snap_t e;
        drive_idle();
        instr_valid = 1'b1;
        Branch_type = 3'd1;
        tick();
        e = exp_snap(m_pc, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (obs_snap() !== e) begin
            n_fail++;
            $display("FAIL rst_eval_pre: got %h expected %h", obs_snap(), e);
        end
        rst_n = 1'b0;
        Zero  = 1'b1;
        tick();
        rst_n = 1'b1;
        m_pc = RESET_PC;
        m_bcnt = 0;
        m_tcnt = 0;
        e = exp_snap(m_pc, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs_snap() !== e) begin
            n_fail++;
            $display("FAIL rst_eval: got %h expected %h", obs_snap(), e);
        end
    endtask

    task automatic test_wrap_saturation();
        do_branch(3'd2, 32'hFFFF_FFFF, 1'b0, $urandom(), 0, "bne_minus1");
        do_branch(3'd2, 32'hFFFF_FFFE, 1'b0, $urandom(), 0, "bne_minus2_wrap");
        do_seq(3'd0, 1'b1, "seq_wrap");
        for (int i = 0; i < 3; i++) do_branch(3'd1, 32'd0, 1'b1, $urandom(), 0, "beq_sat");
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            int unsigned kind = $urandom_range(0, 9);
            if (kind <= 2) begin
                do_seq((kind == 0) ? 3'd0 : 3'($urandom_range(6, 7)), 1'($urandom()), "rnd_seq");
            end else if (kind == 3) begin
                do_jump(26'($urandom()), 3'($urandom()), "rnd_jump");
            end else begin
                do_branch(3'($urandom_range(1, 5)), $urandom(), 1'($urandom()),
                          ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom(),
                          int'($urandom_range(0, 2)), "rnd_branch");
            end
        end
    endtask

    initial begin
        drive_idle();
        rst_n = 1'b0;
        m_pc = RESET_PC;
        m_bcnt = 0;
        m_tcnt = 0;
        test_reset();
        test_sequential();
        test_beq_taken();
        test_bgtz_blez();
        test_jump_priority();
        test_stall();
        test_reset_in_eval();
        test_wrap_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
